conv_accum_stage: RTL and testbench

//  Downstream of the 9 approximate shift-multipliers: takes their nine 16-bit signed Q2.14

---
 rtl/conv_pkg.sv | 47 ++++
 rtl/conv_add3.sv | 23 ++
 rtl/conv_accum_stage.sv | 133 +++++++++++++
 tb/tb_conv_accum_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared widths, stage tag type and the accumulator-to-pixel round/saturate helper
// for the convolution accumulate stage.
package conv_pkg;

    localparam int PROD_W     = 16;
    localparam int N_PROD     = 9;
    localparam int OUT_W      = 8;
    localparam int FRAC_SHIFT = 7;
    localparam int ACC_W      = 24;
    localparam int S1_W       = PROD_W + 2;
    localparam int S2_W       = PROD_W + 4;

    localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(1 << (FRAC_SHIFT - 1));
    localparam logic signed [ACC_W:0] OUT_MAX  = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] OUT_MIN  = (ACC_W+1)'(-(1 << (OUT_W - 1)));

    typedef struct packed {
        logic             sat;
        logic [OUT_W-1:0] data;
    } pix_t;

    // Per-beat side info that travels down the pipeline with the products.
    typedef struct packed {
        logic             last;
        logic             first;
        logic [OUT_W-1:0] bias;
    } tag_t;

    // One extra bit of headroom so the rounding add can never wrap.
    function automatic pix_t sat_round(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W:0] r;
        pix_t p;
        r = ($signed({acc[ACC_W-1], acc}) + RND_HALF) >>> FRAC_SHIFT;
        if (r > OUT_MAX) begin
            p.sat  = 1'b1;
            p.data = OUT_MAX[OUT_W-1:0];
        end else if (r < OUT_MIN) begin
            p.sat  = 1'b1;
            p.data = OUT_MIN[OUT_W-1:0];
        end else begin
            p.sat  = 1'b0;
            p.data = r[OUT_W-1:0];
        end
        return p;
    endfunction

endpackage

// File: rtl/conv_add3.sv
// Registered three-input signed adder; one partial sum of the first adder-tree level.
module conv_add3
    import conv_pkg::*;
#(
    parameter int W = PROD_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic signed [W-1:0] c,
    output logic signed [W+1:0] sum
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sum <= '0;
        else if (en)
            sum <= (W+2)'(a) + (W+2)'(b) + (W+2)'(c);
    end

endmodule

// File: rtl/conv_accum_stage.sv
// Adder tree + channel accumulator: sums nine Q2.14 products per beat, accumulates
// across channel beats, and emits one rounded/saturated Q1.7 pixel per pixel.
module conv_accum_stage
    import conv_pkg::*;
#(
    parameter int MAX_CH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_PROD*PROD_W-1:0] in_prod,
    input  logic                     in_last,
    input  logic [OUT_W-1:0]         bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_sat,
    output logic                     ch_err
);

    localparam int CNT_W  = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
    localparam int N_GRP  = N_PROD / 3;
    localparam int STAGES = 1;   // vld_pipe[0] = S1, vld_pipe[1] = S2

    logic                    en;
    logic                    accept;
    logic                    at_max;
    logic                    beat_last;
    logic                    first;
    logic [CNT_W-1:0]        ch_cnt;
    tag_t                    tag_in;
    logic [STAGES:0]         vld_pipe;
    tag_t [STAGES:0]         tag_pipe;
    logic signed [PROD_W-1:0] prod [N_PROD];
    logic signed [S1_W-1:0]  part [N_GRP];
    logic signed [S2_W-1:0]  s2;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_next;
    pix_t                    pix;

    // The whole pipeline freezes while a finished pixel waits for the consumer.
    assign en        = ~out_valid | out_ready;
    assign in_ready  = en;
    assign accept    = in_valid & en;
    assign at_max    = (ch_cnt == CNT_W'(MAX_CH - 1));
    assign beat_last = in_last | at_max;

    assign tag_in.last  = beat_last;
    assign tag_in.first = first;
    assign tag_in.bias  = bias;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first  <= 1'b1;
            ch_cnt <= '0;
            ch_err <= 1'b0;
        end else if (accept) begin
            if (beat_last) begin
                first  <= 1'b1;
                ch_cnt <= '0;
            end else begin
                first  <= 1'b0;
                ch_cnt <= ch_cnt + CNT_W'(1);
            end
            if (at_max && !in_last)
                ch_err <= 1'b1;
        end
    end

    // S1: three registered partial sums of three products each.
    for (genvar k = 0; k < N_PROD; k++) begin : g_unpack
        assign prod[k] = in_prod[k*PROD_W +: PROD_W];
    end

    for (genvar g = 0; g < N_GRP; g++) begin : g_s1
        conv_add3 #(.W(PROD_W)) u_add3 (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .a     (prod[3*g]),
            .b     (prod[3*g+1]),
            .c     (prod[3*g+2]),
            .sum   (part[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
            s2       <= '0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], accept};
            tag_pipe <= {tag_pipe[STAGES-1:0], tag_in};
            s2       <= S2_W'(part[0]) + S2_W'(part[1]) + S2_W'(part[2]);
        end
    end

    // A first beat restarts from the bias, so stale acc content after a pixel is ignored.
    always_comb begin
        acc_base = acc;
        if (tag_pipe[STAGES].first)
            acc_base = ACC_W'($signed(tag_pipe[STAGES].bias)) <<< FRAC_SHIFT;
        acc_next = acc_base + ACC_W'(s2);
        pix      = sat_round(acc_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (en && vld_pipe[STAGES])
            acc <= acc_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            if (vld_pipe[STAGES] && tag_pipe[STAGES].last) begin
                out_valid <= 1'b1;
                out_data  <= pix.data;
                out_sat   <= pix.sat;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_accum_stage.sv
// Directed + randomized bench for conv_accum_stage with a pixel-level reference model.
module tb_conv_accum_stage;

    localparam int MAXC = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [143:0] in_prod = '0;
    logic         in_last = 1'b0;
    logic [7:0]   bias = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [7:0]   out_data;
    logic         out_sat;
    logic         ch_err;

    always #5 clk = ~clk;

    conv_accum_stage #(.MAX_CH(MAXC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .ch_err    (ch_err)
    );

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q [$];
    bit         m_first = 1'b1;
    int         m_cnt = 0;
    int         m_sum = 0;
    int         m_bias = 0;
    bit         exp_err = 1'b0;
    bit         rnd = 1'b0;
    int         bp_release = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: a pixel is bias*2^7 plus the plain sum of all its products,
    // rounded half up to a multiple of 2^7 and clamped to the signed 8-bit range.
    task automatic model_beat(input logic [8:0][15:0] p, input logic last, input logic [7:0] b);
        int v, r;
        bit sat;
        if (m_first) begin
            m_bias = int'($signed(b));
            m_sum  = 0;
        end
        for (int k = 0; k < 9; k++)
            m_sum += int'($signed(p[k]));
        m_cnt++;
        m_first = 1'b0;
        if (last || m_cnt == MAXC) begin
            if (!last) exp_err = 1'b1;
            v   = m_sum + m_bias * 128;
            r   = (v + 64) >>> 7;
            sat = (r > 127) || (r < -128);
            if (r > 127)  r = 127;
            if (r < -128) r = -128;
            exp_q.push_back({sat, r[7:0]});
            m_first = 1'b1;
            m_cnt   = 0;
        end
    endtask

    task automatic model_reset();
        m_first = 1'b1;
        m_cnt   = 0;
        exp_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic send_beat(input logic [8:0][15:0] p, input logic last, input logic [7:0] b);
        logic rdy;
        rdy      = 1'b0;
        in_prod  = p;
        in_last  = last;
        bias     = b;
        in_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            if (bp_release != 0 && n + 1 >= bp_release) out_ready = 1'b1;
        end
        in_valid = 1'b0;
        check("accept_timeout", {31'd0, rdy}, 32'd1);
        if (rdy) model_beat(p, last, b);
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_all(input logic [15:0] v, input logic last, input logic [7:0] b);
        logic [8:0][15:0] p;
        for (int k = 0; k < 9; k++) p[k] = v;
        send_beat(p, last, b);
    endtask

    task automatic wait_out(input string tag, input logic [7:0] d, input logic s);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_valid"}, {31'd0, seen}, 32'd1);
        check({tag, "_data"}, {24'd0, out_data}, {24'd0, d});
        check({tag, "_sat"}, {31'd0, out_sat}, {31'd0, s});
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every handshaken pixel must match the model's next pixel.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n && out_valid && out_ready) begin
            check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_data", {24'd0, out_data}, {24'd0, e[7:0]});
                check("sb_sat", {31'd0, out_sat}, {31'd0, e[8]});
            end
        end
    end

    initial begin
        logic [8:0][15:0] p;

        // 1: reset state, mid-stream reset, first-pixel latency
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        rst_n = 1'b1;
        send_all(16'h0100, 1'b0, 8'd20);
        send_all(16'h0100, 1'b0, 8'd20);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_data", {24'd0, out_data}, 32'd0);
        check("mid_rst_ch_err", {31'd0, ch_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_all(16'h0080, 1'b1, 8'h00);
        @(negedge clk);
        check("lat_t1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_t2", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_t3", {31'd0, out_valid}, 32'd1);
        check("lat_data", {24'd0, out_data}, 32'h09);
        check("lat_sat", {31'd0, out_sat}, 32'd0);
        @(posedge clk);
        #1;

        // 2: sign and rounding
        send_all(16'hFF80, 1'b1, 8'h00);
        wait_out("neg", 8'hF7, 1'b0);
        send_all(16'h0040, 1'b1, 8'h00);
        wait_out("round", 8'h05, 1'b0);

        // 3: saturation
        send_all(16'h4000, 1'b1, 8'h00);
        wait_out("sat_pos", 8'h7F, 1'b1);
        send_all(16'hC000, 1'b1, 8'h00);
        wait_out("sat_neg", 8'h80, 1'b1);
        send_all(16'h0000, 1'b1, 8'h7F);
        wait_out("bias_max", 8'h7F, 1'b0);

        // 4: multi-channel, bias only taken from the first beat
        send_all(16'h0080, 1'b0, 8'd10);
        send_all(16'h0080, 1'b0, 8'd50);
        send_all(16'h0080, 1'b1, 8'd50);
        wait_out("multi_ch", 8'd37, 1'b0);
        check("ch_err_clean", {31'd0, ch_err}, 32'd0);

        // 5: backpressure holds the result and stalls the input
        out_ready = 1'b0;
        send_all(16'h0080, 1'b1, 8'd0);
        send_all(16'h0080, 1'b1, 8'd10);
        send_all(16'h0080, 1'b1, 8'd20);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_data", {24'd0, out_data}, 32'h09);
        end
        @(posedge clk);
        #1;
        bp_release = 1;
        send_all(16'h0080, 1'b1, 8'd30);
        bp_release = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("bp_stream", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk);
        #1;

        // 6: channel overflow forces the pixel out and flags ch_err
        send_all(16'h0080, 1'b0, 8'd5);
        send_all(16'h0080, 1'b0, 8'd99);
        send_all(16'h0080, 1'b0, 8'd99);
        send_all(16'h0080, 1'b0, 8'd99);
        check("ch_err_set", {31'd0, ch_err}, 32'd1);
        wait_out("forced_last", 8'd41, 1'b0);
        send_all(16'h0080, 1'b1, 8'hFD);
        wait_out("fresh_pixel", 8'd6, 1'b0);
        check("ch_err_sticky", {31'd0, ch_err}, 32'd1);

        // Random stream with random backpressure and bubbles
        rnd = 1'b1;
        for (int i = 0; i < 150; i++) begin
            for (int k = 0; k < 9; k++)
                p[k] = ($urandom_range(0, 1) != 0) ? 16'($urandom)
                                                   : 16'($signed($urandom_range(0, 1023)) - 512);
            send_beat(p, $urandom_range(0, 2) == 0, 8'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        rnd = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", exp_q.size(), 32'd0);
        check("ch_err_final", {31'd0, ch_err}, {31'd0, exp_err});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
